// File: rtl/fifo_reader_pkg.sv
// fifo_reader shared types and defaults.
// FSM state encoding and beat counter sizing helper.
package fifo_reader_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_BURST_LEN = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        TWO  = 2'd2
    } state_t;

    function automatic int beat_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus downstream stream port of fifo_reader.
// master is the reader side, slave is FIFO + sink side.
interface fifo_reader_if
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             empty;
    logic [WIDTH-1:0] rdata;
    logic             ren;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [15:0]      pop_count;

    modport master (
        input  empty,
        input  rdata,
        input  out_ready,
        output ren,
        output out_valid,
        output out_data,
        output out_last,
        output pop_count
    );

    modport slave (
        output empty,
        output rdata,
        output out_ready,
        input  ren,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  pop_count
    );

endinterface

// File: rtl/fifo_reader.sv
// FWFT async-FIFO reader with a two-entry skid buffer,
// burst beat tagging and a wrapping pop counter.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic          rclk,
    input  logic          rrst,
    fifo_reader_if.master bus
);

    localparam int            BW   = beat_w(BURST_LEN);
    localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

    state_t           state;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;
    logic [BW-1:0]    beat;
    logic [15:0]      cnt;
    logic             pop;
    logic             accept;

    // pop only while a slot is free; reset masks it at once
    assign pop           = !rrst && !bus.empty && (state != TWO);
    assign bus.ren       = pop;
    assign bus.out_valid = (state != IDLE);
    assign accept        = bus.out_valid && bus.out_ready;
    assign bus.out_data  = head;
    assign bus.out_last  = bus.out_valid && (beat == LAST);
    assign bus.pop_count = cnt;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state <= IDLE;
            head  <= '0;
            skid  <= '0;
            beat  <= '0;
            cnt   <= '0;
        end else begin
            if (pop) begin
                cnt <= cnt + 16'd1;
            end
            if (accept) begin
                beat <= (beat == LAST) ? '0 : beat + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        head  <= bus.rdata;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (pop && accept) begin
                        head <= bus.rdata;
                    end else if (pop) begin
                        skid  <= bus.rdata;
                        state <= TWO;
                    end else if (accept) begin
                        state <= IDLE;
                    end
                end
                TWO: begin
                    if (accept) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: vector table,
// scoreboard queue model, reset and counter-wrap sequences.
module tb_fifo_reader;
    import fifo_reader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_reader_if #(.WIDTH(8)) bus ();
    fifo_reader_if #(.WIDTH(8)) bus1 ();

    assign bus1.empty     = bus.empty;
    assign bus1.rdata     = bus.rdata;
    assign bus1.out_ready = bus.out_ready;

    fifo_reader #(.WIDTH(8), .BURST_LEN(4)) dut (
        .rclk (clk),
        .rrst (rst),
        .bus  (bus)
    );

    fifo_reader #(.WIDTH(8), .BURST_LEN(1)) dut1 (
        .rclk (clk),
        .rrst (rst),
        .bus  (bus1)
    );

    typedef struct {
        logic       e;
        logic [7:0] d;
        logic       r;
        logic       ren;
        logic       v;
        logic [7:0] data;
        logic       last;
    } vec_t;

    vec_t        tv[11];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  q[$];
    int          mbeat;
    logic [15:0] mcount;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mbeat  = 0;
        mcount = '0;
    endtask

    // drive one cycle at negedge, check vs model, advance model
    task automatic step(input logic e, input logic [7:0] d, input logic r);
        logic eren;
        logic ev;
        bus.empty     = e;
        bus.rdata     = d;
        bus.out_ready = r;
        #1;
        eren = !e && (q.size() < 2);
        ev   = (q.size() != 0);
        chk("ren", bus.ren, eren);
        chk("valid", bus.out_valid, ev);
        chk("pop_count", bus.pop_count, mcount);
        if (ev) begin
            chk("data", bus.out_data, q[0]);
            chk("last", bus.out_last, mbeat == 3);
        end else begin
            chk("last_idle", bus.out_last, 1'b0);
        end
        chk("b1_valid", bus1.out_valid, ev);
        chk("b1_last", bus1.out_last, ev);
        if (ev && r) begin
            void'(q.pop_front());
            mbeat = (mbeat + 1) % 4;
        end
        if (eren) begin
            q.push_back(d);
            mcount = mcount + 16'd1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.empty     = 1'b0;
        bus.rdata     = 8'h5a;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_ren", bus.ren, 1'b0);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_last", bus.out_last, 1'b0);
        chk("rst_b1_ren", bus1.ren, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_data", bus.out_data, 8'h00);
        chk("rst_pop_count", bus.pop_count, 16'h0000);
        chk("rst_ren_hold", bus.ren, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        tv[0]  = '{1'b0, 8'ha5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tv[1]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'ha5, 1'b0};
        tv[2]  = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tv[3]  = '{1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0};
        tv[4]  = '{1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0};
        tv[5]  = '{1'b0, 8'h03, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0};
        tv[6]  = '{1'b0, 8'h03, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0};
        tv[7]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1};
        tv[8]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tv[9]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tv[10] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

        rst = 1'b1;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            bus.empty     = tv[i].e;
            bus.rdata     = tv[i].d;
            bus.out_ready = tv[i].r;
            #1;
            chk($sformatf("tv%0d_ren", i), bus.ren, tv[i].ren);
            chk($sformatf("tv%0d_valid", i), bus.out_valid, tv[i].v);
            chk($sformatf("tv%0d_last", i), bus.out_last, tv[i].last);
            if (tv[i].v) begin
                chk($sformatf("tv%0d_data", i), bus.out_data, tv[i].data);
            end
            step(tv[i].e, tv[i].d, tv[i].r);
        end
        chk("tv_pop_count", bus.pop_count, 16'd4);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'(8'h10 + i), 1'b1);
        end
        step(1'b1, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b1);

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom_range(0, 1)));
        end

        do_reset();
        step(1'b0, 8'h20, 1'b1);
        step(1'b0, 8'h21, 1'b1);
        step(1'b0, 8'h22, 1'b1);
        step(1'b0, 8'h23, 1'b0);
        bus.empty = 1'b0;
        #1;
        chk("two_ren", bus.ren, 1'b0);
        chk("two_data", bus.out_data, 8'h22);
        chk("two_last", bus.out_last, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_ren", bus.ren, 1'b0);
        chk("midrst_last", bus.out_last, 1'b0);
        chk("midrst_pop_count", bus.pop_count, 16'h0000);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'(8'h30 + i), 1'b1);
        end
        step(1'b1, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b1);

        do_reset();
        for (int i = 0; i < 65535; i++) begin
            step(1'b0, 8'(i), 1'b1);
        end
        #1;
        chk("wrap_pre", bus.pop_count, 16'hffff);
        step(1'b0, 8'h77, 1'b1);
        step(1'b1, 8'h00, 1'b1);
        chk("wrap_post", bus.pop_count, 16'h0000);
        step(1'b1, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width matching the async FIFO read port.
REQ-002 SHALL have parameter BURST_LEN, default 4, number of output beats per burst (out_last period); legal range 1..256.
REQ-003 SHALL have port rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-004 SHALL have port rrst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port empty  input  1  FIFO empty flag, rclk domain.
REQ-006 SHALL have port rdata  input  WIDTH  FIFO head word, first-word-fall-through: valid whenever empty=0.
REQ-007 SHALL have port ren  output  1  FIFO pop request.
REQ-008 SHALL have port out_valid  output  1  output word valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts word.
REQ-010 SHALL have port out_data  output  WIDTH  output word.
REQ-011 SHALL have port out_last  output  1  final beat of current burst.
REQ-012 SHALL have port pop_count  output  16  total words popped, wrapping.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE (0 words held), ONE (head register full), TWO (head + skid register full).
REQ-014 SHALL drive ren = !empty && (state != TWO), combinationally; pop = ren (empty=1 forces no pop).
REQ-015 SHALL define accept = out_valid && out_ready; out_valid = (state != IDLE), registered-state derived, no combinational path from out_ready to out_valid.
REQ-016 IDLE: pop -> ONE, head <= rdata; no pop -> stay IDLE.
REQ-017 ONE: pop && accept -> ONE, head <= rdata; pop && !accept -> TWO, skid <= rdata; !pop && accept -> IDLE; neither -> hold.
REQ-018 TWO: accept -> ONE, head <= skid; !accept -> hold; ren=0 in TWO.
REQ-019 out_data SHALL equal head; head and out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 Latency: word popped at edge N SHALL appear on out_data with out_valid=1 from edge N when buffer was IDLE (1 cycle after ren), and words SHALL leave in exact pop order.
REQ-021 Sustained throughput SHALL be one word per cycle when empty=0 and out_ready=1 continuously.
REQ-022 A beat counter (width clog2(BURST_LEN), min 1) SHALL increment on accept and wrap to 0 after BURST_LEN-1; out_last = out_valid && (beat == BURST_LEN-1).
REQ-023 BURST_LEN=1 SHALL give out_last = out_valid on every beat.
REQ-024 pop_count SHALL increment by 1 on each cycle with ren=1, wrapping 0xFFFF -> 0x0000.
REQ-025 Simultaneous pop and accept in ONE SHALL neither lose nor duplicate a word; occupancy unchanged.
REQ-026 out_ready toggling while out_valid=0 SHALL have no effect.

Reset
REQ-027 rrst=1 SHALL immediately force state IDLE, out_valid=0, out_last=0, head=0, skid=0, beat=0, pop_count=0.
REQ-028 ren SHALL be 0 while rrst=1 regardless of empty.
REQ-029 Reset mid-operation SHALL discard held words; first word after release SHALL start a new burst at beat 0.
REQ-030 Release of rrst SHALL be synchronous to rclk (system-guaranteed); first pop no earlier than first rclk edge after release.

Structure
REQ-031 Package fifo_reader_pkg SHALL hold the FSM state enum (IDLE, ONE, TWO) and default parameter constants.
REQ-032 No sub-module; FSM, head/skid registers and counters SHALL live in fifo_reader.
REQ-033 ren/empty/rdata SHALL connect directly to ASYNC_FIFO read port without added synchronizers.

Verification
REQ-034 Reset then empty=0, rdata=0xA5, out_ready=1 -> ren=1, next cycle out_valid=1, out_data=0xA5, pop_count=1.
REQ-035 Words 0x01..0x03 available, out_ready=0 -> after 2 pops state TWO, ren=0, out_data=0x01 held; out_ready=1 -> outputs 0x01,0x02,0x03 in order.
REQ-036 Continuous stream 0x10..0x17, out_ready=1, BURST_LEN=4 -> out_last=1 on 0x13 and 0x17 only, one word per cycle.
REQ-037 Preload pop_count via 65535 pops -> next pop gives pop_count=0x0000.
REQ-038 rrst=1 asserted in state TWO mid-burst (beat=2) -> same cycle out_valid=0, ren=0; after release next word carries beat 0, out_last per fresh burst.
REQ-039 empty=1 throughout with out_ready toggling -> ren=0, out_valid=0, pop_count unchanged.
